// File: rtl/qpp_addr_gen.sv
// LTE QPP interleaver address counter: sequential index or f(i) = (F1*i + F2*i^2) mod K, built from adders only.
// Optional range checker enabled by defining ILV_ADDR_CHECK_EN; otherwise addr_err is tied low.
module qpp_addr_gen #(
    parameter int AW   = 13,
    parameter int K0   = 1056,
    parameter int F1_0 = 17,
    parameter int F2_0 = 66,
    parameter int K1   = 6144,
    parameter int F1_1 = 263,
    parameter int F2_1 = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctr_re,
    input  logic          ctr_en,
    input  logic          ctr_blk,
    input  logic          pmode,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] idx,
    output logic          ctr_finish,
    output logic          addr_err
);
    // state | meaning
    // CLEAR | restarted, element 0 presented, nothing consumed yet
    // RUN   | consuming elements
    // DONE  | all K elements consumed, counters frozen on the last element
    typedef enum logic [1:0] {CLEAR = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [AW-1:0] G0_0 = AW'((F1_0 + F2_0) % K0);
    localparam logic [AW-1:0] G0_1 = AW'((F1_1 + F2_1) % K1);
    localparam logic [AW-1:0] D_0  = AW'((2 * F2_0) % K0);
    localparam logic [AW-1:0] D_1  = AW'((2 * F2_1) % K1);

    state_t        r_state, w_state_nxt;
    logic          r_blk, w_blk_nxt;
    logic [AW-1:0] r_i, w_i_nxt;
    logic [AW-1:0] r_f, w_f_nxt;
    logic [AW-1:0] r_g, w_g_nxt;
    logic [AW-1:0] w_k, w_d;
    logic          w_adv, w_last;

    // Both operands are already reduced below k, so one conditional subtract suffices.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] k);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k})
            s = s - {1'b0, k};
        return s[AW-1:0];
    endfunction

    assign w_k    = r_blk ? AW'(K1) : AW'(K0);
    assign w_d    = r_blk ? D_1 : D_0;
    assign w_adv  = !ctr_re && ctr_en && (r_state != DONE);
    assign w_last = (r_i == w_k - AW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_blk   <= 1'b0;
            r_i     <= '0;
            r_f     <= '0;
            r_g     <= G0_0;
        end else begin
            r_state <= w_state_nxt;
            r_blk   <= w_blk_nxt;
            r_i     <= w_i_nxt;
            r_f     <= w_f_nxt;
            r_g     <= w_g_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_blk_nxt   = r_blk;
        w_i_nxt     = r_i;
        w_f_nxt     = r_f;
        w_g_nxt     = r_g;
        if (ctr_re) begin
            w_state_nxt = CLEAR;
            w_blk_nxt   = ctr_blk;
            w_i_nxt     = '0;
            w_f_nxt     = '0;
            w_g_nxt     = ctr_blk ? G0_1 : G0_0;
        end else if (w_adv) begin
            // The last element is held on the outputs rather than stepping past K-1.
            if (w_last) begin
                w_state_nxt = DONE;
            end else begin
                w_state_nxt = RUN;
                w_i_nxt     = r_i + AW'(1);
                w_f_nxt     = mod_add(r_f, r_g, w_k);
                w_g_nxt     = mod_add(r_g, w_d, w_k);
            end
        end
    end

    assign addr       = pmode ? r_f : r_i;
    assign idx        = r_i;
    assign ctr_finish = (r_state == DONE);

`ifdef ILV_ADDR_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err <= 1'b0;
        else if ((r_state == RUN) && ((r_f >= w_k) || (r_i >= w_k)))
            r_err <= 1'b1;
    end
    assign addr_err = r_err;
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_qpp_addr_gen.sv
// Self-checking bench for qpp_addr_gen: scoreboard of QPP addresses from a direct (multiplying) reference model.
module tb_qpp_addr_gen;
    localparam int AW = 13;
    localparam int K0 = 1056, F1_0 = 17, F2_0 = 66;
    localparam int K1 = 6144, F1_1 = 263, F2_1 = 480;

    logic clk = 1'b0;
    logic reset, ctr_re, ctr_en, ctr_blk, pmode;
    logic [AW-1:0] addr, idx;
    logic ctr_finish, addr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int cap[0:6143];

    qpp_addr_gen #(.AW(AW), .K0(K0), .F1_0(F1_0), .F2_0(F2_0), .K1(K1), .F1_1(F1_1), .F2_1(F2_1)) dut (
        .clk(clk), .reset(reset), .ctr_re(ctr_re), .ctr_en(ctr_en), .ctr_blk(ctr_blk), .pmode(pmode),
        .addr(addr), .idx(idx), .ctr_finish(ctr_finish), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic int qpp(input int k, input int f1, input int f2, input int n);
        longint t;
        t = (longint'(f1) * n + longint'(f2) * n * n) % k;
        return int'(t);
    endfunction

    task automatic restart(input logic blk);
        ctr_re = 1'b1; ctr_blk = blk; ctr_en = 1'b0;
        @(posedge clk); #1;
        ctr_re = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++;
        if (addr !== 0 || idx !== 0 || ctr_finish !== 0 || addr_err !== 0) begin
            n_fail++;
            $display("FAIL reset_state: addr=%0d idx=%0d fin=%0b err=%0b expected all 0", addr, idx, ctr_finish, addr_err);
        end
        reset = 1'b0; pmode = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (addr !== 0 || idx !== 0 || ctr_finish !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: addr=%0d idx=%0d fin=%0b expected 0 0 0", addr, idx, ctr_finish);
        end
    endtask

    // pm: 0 sequential, 1 QPP, 2 pmode changes during the run
    task automatic test_block(input logic blk, input int pm, input bit toggle, input bit perm);
        int k, f1, f2, n, ens, cyc, dups, exp_a;
        bit done;
        bit seen[0:6143];
        k  = blk ? K1 : K0;
        f1 = blk ? F1_1 : F1_0;
        f2 = blk ? F2_1 : F2_0;
        n = 0; ens = 0; done = 0; dups = 0;
        restart(blk);
        exp_q.delete();
        for (int j = 0; j < k; j++) exp_q.push_back(qpp(k, f1, f2, j));
        for (cyc = 0; cyc < 3 * k; cyc++) begin
            ctr_en = toggle ? (cyc % 2 == 0) : 1'b1;
            pmode  = (pm == 2) ? (cyc % 3 == 0) : pm[0];
            @(negedge clk);
            if (ctr_finish) begin
                done = 1;
                break;
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: still running at idx=%0d, expected finished", idx);
                break;
            end
            exp_a = pmode ? exp_q[0] : n;
            if (addr !== AW'(exp_a) || idx !== AW'(n)) begin
                n_fail++;
                $display("FAIL seq_addr blk=%0b n=%0d: addr=%0d idx=%0d expected %0d %0d", blk, n, addr, idx, exp_a, n);
            end
            if (pm == 1) begin
                cap[n] = int'(addr);
                if (seen[addr]) dups++;
                seen[addr] = 1'b1;
            end
            @(posedge clk); #1;
            if (ctr_en) begin
                void'(exp_q.pop_front());
                n++;
                ens++;
            end
        end
        n_checks++;
        if (!done || ens != k || cyc != (toggle ? 2 * k - 1 : k)) begin
            n_fail++;
            $display("FAIL finish_timing blk=%0b: done=%0b enables=%0d cycles=%0d expected 1 %0d %0d",
                     blk, done, ens, cyc, k, toggle ? 2 * k - 1 : k);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d entries remain, expected 0", exp_q.size());
        end
        if (perm) begin
            n_checks++;
            if (dups != 0) begin
                n_fail++;
                $display("FAIL permutation: %0d duplicate addresses, expected 0", dups);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_known(input int k, input int a1, input int a2, input int a3, input int alast);
        n_checks++;
        if (cap[1] != a1 || cap[2] != a2 || cap[3] != a3 || cap[k-1] != alast) begin
            n_fail++;
            $display("FAIL known_values k=%0d: got %0d %0d %0d last %0d expected %0d %0d %0d last %0d",
                     k, cap[1], cap[2], cap[3], cap[k-1], a1, a2, a3, alast);
        end
    endtask

    task automatic test_done_hold();
        ctr_en = 1'b1; pmode = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (addr !== 217 || idx !== K1 - 1 || ctr_finish !== 1'b1) begin
                n_fail++;
                $display("FAIL done_hold c=%0d: addr=%0d idx=%0d fin=%0b expected 217 %0d 1", c, addr, idx, ctr_finish, K1 - 1);
            end
            @(posedge clk); #1;
        end
        pmode = 1'b0; #1;
        n_checks++;
        if (addr !== K1 - 1) begin
            n_fail++;
            $display("FAIL done_seq_addr: addr=%0d expected %0d", addr, K1 - 1);
        end
    endtask

    task automatic test_mid_restart();
        restart(1'b0);
        pmode = 1'b1; ctr_en = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        n_checks++;
        if (idx !== 500 || addr !== AW'(qpp(K0, F1_0, F2_0, 500))) begin
            n_fail++;
            $display("FAIL mid_i500: idx=%0d addr=%0d expected 500 %0d", idx, addr, qpp(K0, F1_0, F2_0, 500));
        end
        ctr_re = 1'b1; ctr_blk = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (idx !== 0 || addr !== 0 || ctr_finish !== 0) begin
                n_fail++;
                $display("FAIL restart_wins c=%0d: idx=%0d addr=%0d fin=%0b expected 0 0 0", c, idx, addr, ctr_finish);
            end
        end
        ctr_re = 1'b0; ctr_blk = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (addr !== 743) begin
            n_fail++;
            $display("FAIL relatch_blk: addr=%0d expected 743", addr);
        end
        @(posedge clk); #1;
        n_checks++;
        if (addr !== 2446) begin
            n_fail++;
            $display("FAIL relatch_blk2: addr=%0d expected 2446", addr);
        end
    endtask

    task automatic test_blk_flip();
        restart(1'b0);
        pmode = 1'b1; ctr_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        ctr_blk = 1'b1;
        for (int n = 5; n < 12; n++) begin
            n_checks++;
            if (addr !== AW'(qpp(K0, F1_0, F2_0, n))) begin
                n_fail++;
                $display("FAIL blk_flip n=%0d: addr=%0d expected %0d", n, addr, qpp(K0, F1_0, F2_0, n));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        restart(1'b0);
        pmode = 1'b1; ctr_en = 1'b1;
        repeat (500) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (addr !== 0 || idx !== 0 || ctr_finish !== 0 || addr_err !== 0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%0d idx=%0d fin=%0b err=%0b expected all 0", addr, idx, ctr_finish, addr_err);
        end
        ctr_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; ctr_en = 1'b1; ctr_blk = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (addr !== 83 || idx !== 1) begin
            n_fail++;
            $display("FAIL post_reset_step: addr=%0d idx=%0d expected 83 1", addr, idx);
        end
    endtask

    task automatic test_addr_err();
        restart(1'b0);
        ctr_en = 1'b1; pmode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef ILV_ADDR_CHECK_EN
        force dut.r_f = AW'(K0);
        @(posedge clk); #1;
        release dut.r_f;
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_err_set: err=%0b expected 1", addr_err);
        end
        restart(1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_err_sticky: err=%0b expected 1", addr_err);
        end
`else
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_err_tied: err=%0b expected 0", addr_err);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; ctr_re = 1'b0; ctr_en = 1'b0; ctr_blk = 1'b0; pmode = 1'b0;
        test_reset();
        test_block(1'b0, 1, 1'b0, 1'b1);
        test_known(K0, 83, 298, 645, 49);
        test_block(1'b1, 1, 1'b0, 1'b1);
        test_known(K1, 743, 2446, 5109, 217);
        test_done_hold();
        test_block(1'b0, 0, 1'b1, 1'b0);
        test_block(1'b0, 2, 1'b0, 1'b0);
        test_mid_restart();
        test_blk_flip();
        test_async_reset();
        test_addr_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
